// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux4_scan_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mux4_next_chan.sv
// Priority picker: lowest enabled channel above (or at, when incl) cur.
module mux4_next_chan
    import mux4_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              incl,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        // Descending scan so the lowest qualifying index wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans enabled inputs of a 4:1 mux, settling sel before each capture,
// and assembles the captured bits into a frame.
module mux4_scan_ctrl
    import mux4_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              sample_valid,
    output logic [SEL_W-1:0]  sample_chan,
    output logic              sample_data,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [SEL_W-1:0]  sc_q, sc_d;
    logic              sd_q, sd_d;
    logic              sv_q, sv_d;
    logic              fv_q, fv_d;

    logic              idle;
    logic [NUM_CH-1:0] pk_mask;
    logic [SEL_W-1:0]  pk_cur;
    logic [SEL_W-1:0]  pk_nxt;
    logic              pk_found;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the picker sees the live mask for the first pick.
    assign pk_mask = idle ? chan_en : en_q;
    assign pk_cur  = idle ? '0 : sel_q;

    mux4_next_chan u_pick (
        .mask  (pk_mask),
        .cur   (pk_cur),
        .incl  (idle),
        .nxt   (pk_nxt),
        .found (pk_found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        sel_d   = sel_q;
        frame_d = frame_q;
        sc_d    = sc_q;
        sd_d    = sd_q;
        sv_d    = 1'b0;
        fv_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d = '0;
                    if (chan_en != '0) begin
                        en_d    = chan_en;
                        sel_d   = pk_nxt;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        fv_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                frame_d[sel_q] = mux_out;
                sd_d           = mux_out;
                sc_d           = sel_q;
                sv_d           = 1'b1;
                if (pk_found) begin
                    sel_d   = pk_nxt;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    fv_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= '0;
            sel_q   <= '0;
            frame_q <= '0;
            sc_q    <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            sc_q    <= sc_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            fv_q    <= fv_d;
        end
    end

    assign sel          = sel_q;
    assign busy         = !idle;
    assign sample_valid = sv_q;
    assign sample_chan  = sc_q;
    assign sample_data  = sd_q;
    assign frame        = frame_q;
    assign frame_valid  = fv_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=2 and SETTLE=1) each driving a 4:1 mux.
module tb_mux4_scan_ctrl;

    typedef struct packed {
        logic [1:0] ch;
        logic       d;
    } samp_t;

    typedef struct {
        logic [3:0] fr;
        int         at;
    } frm_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] en0 = '0, en1 = '0;
    logic [3:0] min0 = '0, min1 = '0;
    logic       mout0, mout1;
    logic [1:0] sel0, sel1, sc0, sc1;
    logic       busy0, busy1, sv0, sv1, sd0, sd1, fv0, fv1;
    logic [3:0] fr0, fr1;

    samp_t sq0[$], sq1[$];
    frm_t  fq0[$], fq1[$];

    int n_checks = 0;
    int n_errors = 0;

    // The downstream 4:1 mux: sel[0] picks in the first rank, sel[1] in the second.
    assign mout0 = sel0[1] ? (sel0[0] ? min0[3] : min0[2])
                           : (sel0[0] ? min0[1] : min0[0]);
    assign mout1 = sel1[1] ? (sel1[0] ? min1[3] : min1[2])
                           : (sel1[0] ? min1[1] : min1[0]);

    mux4_scan_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .chan_en(en0),
        .mux_out(mout0), .sel(sel0), .busy(busy0),
        .sample_valid(sv0), .sample_chan(sc0), .sample_data(sd0),
        .frame(fr0), .frame_valid(fv0)
    );

    mux4_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .chan_en(en1),
        .mux_out(mout1), .sel(sel1), .busy(busy1),
        .sample_valid(sv1), .sample_chan(sc1), .sample_data(sd1),
        .frame(fr1), .frame_valid(fv1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon0
        samp_t s;
        frm_t  f;
        if (rst_n) begin
            if (sv0) begin
                if (sq0.size() == 0) chk("dut0_unexpected_sample", 1, 0);
                else begin
                    s = sq0.pop_front();
                    chk("dut0_sample_chan", 32'(sc0), 32'(s.ch));
                    chk("dut0_sample_data", 32'(sd0), 32'(s.d));
                end
            end
            if (fv0) begin
                if (fq0.size() == 0) chk("dut0_unexpected_frame", 1, 0);
                else begin
                    f = fq0.pop_front();
                    chk("dut0_frame", 32'(fr0), 32'(f.fr));
                    chk("dut0_frame_cycle", cyc, f.at);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        samp_t s;
        frm_t  f;
        if (rst_n) begin
            if (sv1) begin
                if (sq1.size() == 0) chk("dut1_unexpected_sample", 1, 0);
                else begin
                    s = sq1.pop_front();
                    chk("dut1_sample_chan", 32'(sc1), 32'(s.ch));
                    chk("dut1_sample_data", 32'(sd1), 32'(s.d));
                end
            end
            if (fv1) begin
                if (fq1.size() == 0) chk("dut1_unexpected_frame", 1, 0);
                else begin
                    f = fq1.pop_front();
                    chk("dut1_frame", 32'(fr1), 32'(f.fr));
                    chk("dut1_frame_cycle", cyc, f.at);
                end
            end
        end
    end

    // Called at a negedge: pulses start for one edge and queues expectations.
    task automatic frame_run(input int inst, input logic [3:0] en,
                             input logic [3:0] mi, input logic [3:0] efr);
        int    e, n, s;
        samp_t sp;
        frm_t  fp;
        e = cyc + 1;
        n = $countones(en);
        s = (inst == 1) ? 1 : 2;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                sp.ch = 2'(i);
                sp.d  = mi[i];
                if (inst == 1) sq1.push_back(sp);
                else sq0.push_back(sp);
            end
        end
        fp.fr = efr;
        fp.at = e + n * (s + 1);
        if (inst == 1) begin
            fq1.push_back(fp);
            min1 = mi; en1 = en; start1 = 1'b1;
        end else begin
            fq0.push_back(fp);
            min0 = mi; en0 = en; start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input logic [3:0] forbid, input bit no_busy);
        bit         done;
        logic       b;
        logic [1:0] s;
        int         qn;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            b  = (inst == 1) ? busy1 : busy0;
            s  = (inst == 1) ? sel1 : sel0;
            qn = (inst == 1) ? fq1.size() : fq0.size();
            if (b && forbid != 4'b0000) chk("sel_forbidden", 32'(forbid[s]), 0);
            if (no_busy) chk("busy_stays_low", 32'(b), 0);
            if (qn == 0 && !b) done = 1'b1;
        end
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_sel"}, 32'(sel0), 0);
        chk({tag, "_busy"}, 32'(busy0), 0);
        chk({tag, "_sv"}, 32'(sv0), 0);
        chk({tag, "_sc"}, 32'(sc0), 0);
        chk({tag, "_sd"}, 32'(sd0), 0);
        chk({tag, "_frame"}, 32'(fr0), 0);
        chk({tag, "_fv"}, 32'(fv0), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e;
        repeat (2) @(negedge clk);
        chk_zero0("rst");
        chk("rst_dut1_busy", 32'(busy1), 0);
        chk("rst_dut1_sel", 32'(sel1), 0);

        // Full mask, start on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        frame_run(0, 4'b1111, 4'b1101, 4'b1101);
        wait_idle(0, 4'b0000, 1'b0);
        chk("t1_frame_hold", 32'(fr0), 32'hd);

        // Sparse mask: sel must never visit 0 or 2.
        @(negedge clk);
        frame_run(0, 4'b1010, 4'b1010, 4'b1010);
        wait_idle(0, 4'b0101, 1'b0);
        chk("t2_sel_idle_hold", 32'(sel0), 3);

        // Empty mask: immediate empty frame, never busy.
        @(negedge clk);
        frame_run(0, 4'b0000, 4'b1111, 4'b0000);
        wait_idle(0, 4'b0000, 1'b1);
        chk("t3_frame_zero", 32'(fr0), 0);
        chk("t3_sel_retained", 32'(sel0), 3);

        // Re-start and mask change mid-frame are ignored.
        @(negedge clk);
        frame_run(0, 4'b1111, 4'b0110, 4'b0110);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        en0 = 4'b0001;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        wait_idle(0, 4'b0000, 1'b0);
        repeat (10) @(negedge clk);
        chk("t4_no_second_frame", 32'(fq0.size() + sq0.size()), 0);
        chk("t4_frame_hold", 32'(fr0), 32'h6);

        // Reset during the settle of channel 2 aborts the frame.
        @(negedge clk);
        en0 = 4'b1111;
        min0 = 4'b1111;
        start0 = 1'b1;
        e = cyc + 1;
        sq0.push_back(samp_t'{ch: 2'd0, d: 1'b1});
        sq0.push_back(samp_t'{ch: 2'd1, d: 1'b1});
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 50 && cyc < e + 7; k++) @(negedge clk);
        chk("t5_sel_ch2", 32'(sel0), 2);
        chk("t5_busy", 32'(busy0), 1);
        chk("t5_two_samples_seen", 32'(sq0.size()), 0);
        #1 rst_n = 1'b0;
        #1 chk_zero0("midrst");
        repeat (3) @(negedge clk);
        chk("t5_no_frame_valid", 32'(fv0), 0);
        rst_n = 1'b1;
        frame_run(0, 4'b1111, 4'b1001, 4'b1001);
        wait_idle(0, 4'b0000, 1'b0);

        // SETTLE=1, single channel: sel stays 0, capture two edges after start.
        @(negedge clk);
        frame_run(1, 4'b0001, 4'b0001, 4'b0001);
        wait_idle(1, 4'b1110, 1'b0);
        chk("t6_frame_hold", 32'(fr1), 1);

        repeat (4) @(negedge clk);
        chk("end_q_sq0", 32'(sq0.size()), 0);
        chk("end_q_fq0", 32'(fq0.size()), 0);
        chk("end_q_sq1", 32'(sq1.size()), 0);
        chk("end_q_fq1", 32'(fq1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
